// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin arbiter that time-shares one 4x4 unsigned
// multiplier among NREQ requesters. Accept -> MUL -> HOLD, one product
// per transaction, result tagged with the requester ID.

// Shared combinational 4x4 -> 8 unsigned multiplier.
module multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] y
);
  assign y = {4'b0, a} * {4'b0, b};
endmodule

module mul_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [4*NREQ-1:0]   req_a,
  input  logic [4*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic                res_valid,
  output logic [IDW-1:0]      res_id,
  output logic [7:0]          res_y,
  input  logic                res_ready
);

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_q;
  logic [IDW-1:0]   id_q;
  logic [3:0]       opa_q, opb_q;
  logic             res_valid_q;
  logic [IDW-1:0]   res_id_q;
  logic [7:0]       res_y_q;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   cand;
  logic             ld_op, ld_res, clr_res;
  logic [7:0]       mul_y;

  // Single shared multiplier, fed only from the registered operands so the
  // product is immune to operand changes after the accept cycle.
  multiplier u_mul (
    .a (opa_q),
    .b (opb_q),
    .y (mul_y)
  );

  // Round-robin search: start one past the last grant, first valid wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_q) + k) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, accept strobe and datapath load enables.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    ld_op     = 1'b0;
    ld_res    = 1'b0;
    clr_res   = 1'b0;
    unique case (state_q)
      IDLE: if (gnt_found) begin
        req_ready[gnt_idx] = 1'b1;
        ld_op              = 1'b1;
        state_d            = MUL;
      end
      MUL: begin
        ld_res  = 1'b1;
        state_d = HOLD;
      end
      HOLD: if (res_ready) begin
        clr_res = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // No accept may be signalled while the block is being reset.
    if (!rst_n) begin
      req_ready = '0;
      ld_op     = 1'b0;
      ld_res    = 1'b0;
      clr_res   = 1'b0;
    end
  end

  // Operand capture, round-robin pointer and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q      <= IDW'(NREQ - 1);
      id_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_y_q     <= '0;
    end else begin
      if (ld_op) begin
        opa_q  <= req_a[{gnt_idx, 2'b00} +: 4];
        opb_q  <= req_b[{gnt_idx, 2'b00} +: 4];
        id_q   <= gnt_idx;
        last_q <= gnt_idx;
      end
      if (ld_res) begin
        res_y_q     <= mul_y;
        res_id_q    <= id_q;
        res_valid_q <= 1'b1;
      end
      if (clr_res) res_valid_q <= 1'b0;
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_y     = res_y_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb: inputs driven on the falling edge,
// outputs sampled 1 time unit later, expected values hand-computed.
module tb_mul_share_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic [7:0]        res_y;
  logic              res_ready;

  int n_cmp = 0;
  int n_err = 0;

  mul_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_y     (res_y),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for res_valid, then check tag and product.
  task automatic wait_result(input string tag, input int id, input int y);
    bit seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk); #1;
      if (res_valid) seen = 1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_id"}, 32'(res_id), 32'(id));
      chk({tag, "_y"},  32'(res_y),  32'(y));
    end
  endtask

  // One full transaction from a single requester; operands are scrambled
  // right after the accept to show the product is unaffected.
  task automatic do_req(input string tag, input int id, input int a, input int b, input int y);
    @(negedge clk);
    req_valid          = '0;
    req_valid[id]      = 1'b1;
    req_a[4*id +: 4]   = 4'(a);
    req_b[4*id +: 4]   = 4'(b);
    res_ready          = 1'b1;
    #1 chk({tag, "_rdy"}, 32'(req_ready), 32'(1) << id);
    @(negedge clk);
    req_valid        = '0;
    req_a[4*id +: 4] = 4'hF;
    req_b[4*id +: 4] = 4'hF;
    #1 chk({tag, "_mulv"}, 32'(res_valid), 32'd0);
    wait_result(tag, id, y);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; res_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ng, nr, exp_r, last_acc;
    bit drop;
    int prod [NREQ];

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;

    // 1. Reset state; req_ready held low during reset even with a request.
    @(negedge clk);
    req_valid = 4'b0001; req_a[3:0] = 4'd3; req_b[3:0] = 4'd5;
    #1 chk("rst_rdy", 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    chk("rst_vld", 32'(res_valid), 32'd0);
    chk("rst_id",  32'(res_id),    32'd0);
    chk("rst_y",   32'(res_y),     32'd0);
    chk("rst_rdy2", 32'(req_ready), 32'd0);
    rst_n = 1'b1; req_valid = '0;
    do_req("t1", 0, 3, 5, 15);

    // 2. Maximum product.
    do_req("t2", 2, 15, 15, 225);

    // 3. All requesters valid: strict rotation 0,1,2,3,0, accepts 3 apart.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[4*i +: 4] = 4'(i + 2);
      req_b[4*i +: 4] = 4'(i + 7);
    end
    prod = '{14, 24, 36, 50};
    req_valid = 4'hF; res_ready = 1'b1;
    ng = 0; nr = 0; exp_r = 0; last_acc = 0; drop = 0;
    for (int c = 0; c < 30 && nr < 5; c++) begin
      if (c > 0) @(negedge clk);
      if (drop) req_valid = '0;
      #1;
      if (req_ready != 0) begin
        chk("t3_gnt", 32'(req_ready), 32'(1) << (ng % NREQ));
        if (ng > 0) chk("t3_gap", 32'(c - last_acc), 32'd3);
        last_acc = c;
        ng++;
        if (ng == 5) drop = 1;
      end
      if (res_valid) begin
        chk("t3_id", 32'(res_id), 32'(exp_r));
        chk("t3_y",  32'(res_y),  32'(prod[exp_r]));
        exp_r = (exp_r + 1) % NREQ;
        nr++;
      end
    end
    chk("t3_ngnt", 32'(ng), 32'd5);
    chk("t3_nres", 32'(nr), 32'd5);

    // 4. Back-pressure: result held stable, no grants until the handshake.
    @(negedge clk);
    req_valid = 4'b0010; req_a[7:4] = 4'd6; req_b[7:4] = 4'd7; res_ready = 1'b0;
    #1 chk("t4_rdy", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = 4'b1000; req_a[7:4] = 4'hF; req_a[15:12] = 4'd2; req_b[15:12] = 4'd3;
    #1 chk("t4_mul_rdy", 32'(req_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      chk("t4_hvld", 32'(res_valid), 32'd1);
      chk("t4_hy",   32'(res_y),     32'd42);
      chk("t4_hid",  32'(res_id),    32'd1);
      chk("t4_hrdy", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    res_ready = 1'b1;
    #1 chk("t4_rel_rdy", 32'(req_ready), 32'd0);
    chk("t4_rel_vld", 32'(res_valid), 32'd1);
    @(negedge clk); #1;
    chk("t4_post_vld", 32'(res_valid), 32'd0);
    chk("t4_resume", 32'(req_ready), 32'b1000);
    @(negedge clk);
    req_valid = '0;
    wait_result("t4b", 3, 6);

    // 5. Reset while in MUL aborts the product and restores the pointer.
    @(negedge clk);
    req_valid = 4'b0010; req_a[7:4] = 4'd9; req_b[7:4] = 4'd9;
    #1 chk("t5_rdy", 32'(req_ready), 32'b0010);
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 chk("t5_novld", 32'(res_valid), 32'd0);
      @(negedge clk);
    end
    req_valid = 4'b0011;
    req_a[3:0] = 4'd4; req_b[3:0] = 4'd4; req_a[7:4] = 4'd5; req_b[7:4] = 4'd5;
    #1 chk("t5_ptr", 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid = '0;
    wait_result("t5r", 0, 16);

    // 6. Zero operands, unit operand, repeat grant and pointer wrap.
    do_req("t6a", 0, 0, 9, 0);
    do_req("t6b", 2, 7, 0, 0);
    do_req("t6c", 3, 1, 9, 9);
    do_req("t6d", 3, 2, 2, 4);
    do_req("t6e", 1, 13, 11, 143);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
